// File: rtl/rv_mem_pkg.sv
// Shared types for the core's memory port: access sizes, arbiter state, owner.
package rv_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_lane_align.sv
// Size + low address bits -> byte enables, lane-shifted store data, misalignment flag.
module mem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o
);

  // Decode lanes; the illegal size encoding is reported as misaligned so the
  // arbiter answers it with an error and never touches memory.
  always_comb begin
    be_o         = 4'b0000;
    misaligned_o = 1'b0;
    wdata_o      = wdata_i << {addr_lo_i, 3'b000};
    case (size_i)
      SZ_B: be_o = 4'b0001 << addr_lo_i;
      SZ_H: begin
        be_o         = 4'b0011 << addr_lo_i;
        misaligned_o = addr_lo_i[0];
      end
      SZ_W: begin
        be_o         = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single memory port between fetch and load/store.
// One transaction outstanding; all outputs registered; bounded by a BUSY timeout.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        ls_req_i,
  input  logic [31:0] ls_addr_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_size_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  state_e      state_q;
  owner_e      last_q;   // most recent grant; also owner of the BUSY transaction
  logic [CW-1:0] cnt_q;

  logic        if_gnt_q, if_rvalid_q, if_err_q;
  logic [31:0] if_rdata_q;
  logic        ls_gnt_q, ls_rvalid_q, ls_err_q;
  logic [31:0] ls_rdata_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic        sel_go, sel_ls, sel_we, sel_mis;
  logic [31:0] sel_addr, sel_wdata, sel_wdata_sh;
  logic [1:0]  sel_size;
  logic [3:0]  sel_be;
  logic [CW-1:0] cnt_inc;
  logic        tmo_hit;

  // Pick a requester. No selection while a grant pulse is out: the requester
  // still holds req through the edge ending its gnt cycle, and after an
  // error-only grant the arbiter is already IDLE in that cycle.
  always_comb begin
    sel_go    = (state_q == ST_IDLE) && !if_gnt_q && !ls_gnt_q && (if_req_i || ls_req_i);
    sel_ls    = ls_req_i && (!if_req_i || (last_q == OWN_IF));
    sel_addr  = sel_ls ? ls_addr_i  : if_addr_i;
    sel_size  = sel_ls ? ls_size_i  : SZ_W;
    sel_wdata = sel_ls ? ls_wdata_i : 32'h0;
    sel_we    = sel_ls && ls_we_i;
    cnt_inc   = cnt_q + 1'b1;
    tmo_hit   = (TIMEOUT != 0) && (cnt_inc == TO_V);
  end

  mem_lane_align u_align (
    .size_i       (sel_size),
    .addr_lo_i    (sel_addr[1:0]),
    .wdata_i      (sel_wdata),
    .be_o         (sel_be),
    .wdata_o      (sel_wdata_sh),
    .misaligned_o (sel_mis)
  );

  // IDLE/BUSY control with registered grant, response and memory-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= OWN_LS;
      cnt_q       <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (sel_go) begin
            last_q   <= sel_ls ? OWN_LS : OWN_IF;
            if_gnt_q <= !sel_ls;
            ls_gnt_q <= sel_ls;
            if (sel_mis) begin
              // Answered immediately with an error; memory is never touched.
              if_rvalid_q <= !sel_ls;
              if_err_q    <= !sel_ls;
              ls_rvalid_q <= sel_ls;
              ls_err_q    <= sel_ls;
            end else begin
              state_q     <= ST_BUSY;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= {sel_addr[31:2], 2'b00};
              mem_we_q    <= sel_we;
              mem_be_q    <= sel_be;
              mem_wdata_q <= sel_wdata_sh;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack_i || tmo_hit) begin
            // Ack takes priority over a timeout expiring in the same cycle.
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= (last_q == OWN_IF);
            ls_rvalid_q <= (last_q == OWN_LS);
            if_err_q    <= (last_q == OWN_IF) && !mem_ack_i;
            ls_err_q    <= (last_q == OWN_LS) && !mem_ack_i;
            if_rdata_q  <= ((last_q == OWN_IF) && mem_ack_i && !mem_we_q) ? mem_rdata_i : 32'h0;
            ls_rdata_q  <= ((last_q == OWN_LS) && mem_ack_i && !mem_we_q) ? mem_rdata_i : 32'h0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign if_err_o    = if_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_gnt_o    = ls_gnt_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_err_o    = ls_err_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table for single transactions, scoreboard
// of expected responses, hand sequences for contention, timeout and reset.
module tb_mem_port_arbiter;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_we_i(ls_we), .ls_size_i(ls_size),
    .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid),
    .ls_rdata_o(ls_rdata), .ls_err_o(ls_err),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ls;
    logic [31:0] addr;
    bit          we;
    logic [1:0]  sz;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          x_mis;
    logic [31:0] x_addr;
    logic [3:0]  x_be;
    logic [31:0] x_wd;
  } vec_t;

  typedef struct {
    bit          ls;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin : mon
    rsp_t e;
    if (!rst && (if_rvalid || ls_rvalid)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got if=%0b ls=%0b expected none", if_rvalid, ls_rvalid);
      end else begin
        e = sbq.pop_front();
        chk("rsp_side", 32'({if_rvalid, ls_rvalid}), e.ls ? 32'd1 : 32'd2);
        chk("rsp_err", 32'(e.ls ? ls_err : if_err), 32'(e.err));
        chk("rsp_rdata", e.ls ? ls_rdata : if_rdata, e.rdata);
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    rsp_t e;
    @(negedge clk);
    e.ls = v.ls;
    e.err = v.x_mis;
    e.rdata = (v.x_mis || v.we) ? 32'h0 : v.rd;
    sbq.push_back(e);
    if (v.ls) begin
      ls_req = 1'b1; ls_addr = v.addr; ls_we = v.we; ls_size = v.sz; ls_wdata = v.wd;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    chk($sformatf("v%0d_gnt", idx), 32'({if_gnt, ls_gnt}), v.ls ? 32'd1 : 32'd2);
    chk($sformatf("v%0d_mem_req", idx), 32'(mem_req), 32'(!v.x_mis));
    if (v.x_mis) begin
      chk($sformatf("v%0d_err_now", idx), 32'({if_rvalid, if_err, ls_rvalid, ls_err}),
          v.ls ? 32'h3 : 32'hC);
    end else begin
      chk($sformatf("v%0d_addr", idx), mem_addr, v.x_addr);
      chk($sformatf("v%0d_be", idx), 32'(mem_be), 32'(v.x_be));
      chk($sformatf("v%0d_wdata", idx), mem_wdata, v.x_wd);
      chk($sformatf("v%0d_we", idx), 32'(mem_we), 32'(v.we));
      mem_ack = 1'b1;
      mem_rdata = v.rd;
    end
    @(posedge clk);
    #1;
    if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    if (!v.x_mis) begin
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", idx), 32'({if_rvalid, ls_rvalid}), v.ls ? 32'd1 : 32'd2);
      chk($sformatf("v%0d_req_drop", idx), 32'(mem_req), 32'd0);
    end
  endtask

  // Word load on LS; ack_at = n-th BUSY cycle to ack in, 0 = never ack.
  task automatic tmo_seq(input int ack_at, input logic [31:0] rd);
    rsp_t e;
    int   n;
    bit   seen;
    n = 0;
    seen = 1'b0;
    @(negedge clk);
    e.ls = 1'b1;
    e.err = (ack_at == 0);
    e.rdata = (ack_at == 0) ? 32'h0 : rd;
    sbq.push_back(e);
    ls_req = 1'b1; ls_addr = 32'h700; ls_we = 1'b0; ls_size = SZ_W;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (ls_rvalid) seen = 1'b1;
      else begin
        if (ls_gnt) ls_req = 1'b0;
        if (mem_req) n++;
        mem_ack = (ack_at != 0) && (n == ack_at);
        mem_rdata = rd;
      end
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    chk($sformatf("tmo%0d_rvalid_seen", ack_at), 32'(seen), 32'd1);
    chk($sformatf("tmo%0d_busy_cycles", ack_at), 32'(n), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    int   gcyc[$];
    bit   gls[$];
    rsp_t e;

    vt[0]  = '{0, 32'h100, 0, SZ_W, 32'h0,        32'h00500093, 0, 32'h100, 4'b1111, 32'h0};
    vt[1]  = '{1, 32'h203, 1, SZ_B, 32'hAB,       32'h99999999, 0, 32'h200, 4'b1000, 32'hAB000000};
    vt[2]  = '{1, 32'h202, 1, SZ_H, 32'h1234,     32'h99999999, 0, 32'h200, 4'b1100, 32'h12340000};
    vt[3]  = '{1, 32'h101, 0, SZ_W, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0};
    vt[4]  = '{0, 32'h102, 0, SZ_W, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0};
    vt[5]  = '{1, 32'h301, 0, SZ_B, 32'h0,        32'hDEADBEEF, 0, 32'h300, 4'b0010, 32'h0};
    vt[6]  = '{1, 32'h203, 0, SZ_H, 32'h0,        32'h0,        1, 32'h0,   4'b0000, 32'h0};
    vt[7]  = '{1, 32'h400, 0, 2'b11, 32'h0,       32'h0,        1, 32'h0,   4'b0000, 32'h0};
    vt[8]  = '{1, 32'h404, 1, SZ_W, 32'hCAFEF00D, 32'h99999999, 0, 32'h404, 4'b1111, 32'hCAFEF00D};
    vt[9]  = '{1, 32'h001, 1, SZ_B, 32'h55,       32'h99999999, 0, 32'h0,   4'b0010, 32'h00005500};
    vt[10] = '{1, 32'h000, 0, SZ_H, 32'h0,        32'h11223344, 0, 32'h0,   4'b0011, 32'h0};

    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_addr = 32'h0; ls_we = 1'b0; ls_size = SZ_W; ls_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'({if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_req, mem_we, mem_be}), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", if_rdata | ls_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 32'({if_gnt, ls_gnt, mem_req}), 32'd0);

    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    tmo_seq(0, 32'h0);
    tmo_seq(4, 32'h12345678);

    // Reset in the second BUSY cycle of a load.
    @(negedge clk);
    ls_req = 1'b1; ls_addr = 32'h800; ls_we = 1'b0; ls_size = SZ_W;
    @(negedge clk);
    ls_req = 1'b0;
    chk("rstmid_busy1", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("rstmid_busy2", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_drop", 32'({mem_req, if_gnt, ls_gnt, if_rvalid, ls_rvalid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      chk("rstmid_no_rvalid", 32'({if_rvalid, ls_rvalid, mem_req}), 32'd0);
      @(negedge clk);
    end

    // Contention: both held, ack in the grant cycle; IF first after reset.
    if_req = 1'b1; if_addr = 32'h600;
    ls_req = 1'b1; ls_addr = 32'h500; ls_we = 1'b0; ls_size = SZ_W;
    for (int cyc = 0; cyc < 20 && gls.size() < 4; cyc++) begin
      @(negedge clk);
      mem_ack = mem_req;
      mem_rdata = 32'hA0000000 + 32'(cyc);
      if (if_gnt || ls_gnt) begin
        gcyc.push_back(cyc);
        gls.push_back(ls_gnt);
        e.ls = ls_gnt;
        e.err = 1'b0;
        e.rdata = mem_rdata;
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if_req = 1'b0; ls_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("cont_grants", 32'(gls.size()), 32'd4);
    for (int k = 0; k < gls.size(); k++)
      chk($sformatf("cont_order%0d", k), 32'(gls[k]), 32'(k % 2));
    for (int k = 1; k < gcyc.size(); k++)
      chk($sformatf("cont_spacing%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd2);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
